// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I decode-stage hazard/forwarding/flush controller.
// Define HAZARD_FWD_EN to enable EX/MEM/WB forwarding with 1-cycle load-use stall.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_reg_write,
    input  logic             i_id_load,
    input  logic             i_id_redirect,
    output logic             o_dec_valid,
    output logic             o_stall_if,
    output logic             o_bubble_ex,
    output logic             o_flush_if,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [1:0] LP_FLUSH_INIT = 2'(FLUSH_CYCLES);

    logic             r_ex_v, r_ex_wr, r_ex_ld;
    logic [4:0]       r_ex_rd;
    logic             r_mem_v, r_mem_wr;
    logic [4:0]       r_mem_rd;
    logic             r_wb_v, r_wb_wr;
    logic [4:0]       r_wb_rd;
    logic [1:0]       r_flush_ctr;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_dec_valid;
    logic w_hazard;
    logic w_stall;
    logic w_redirect_acc;
    logic w_a_ex, w_a_mem, w_a_wb;
    logic w_b_ex, w_b_mem, w_b_wb;

    function automatic logic f_match(input logic v, input logic wr, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic use_rs);
        return v & wr & (rd != 5'd0) & (rd == rs) & use_rs;
    endfunction

    assign w_a_ex  = f_match(r_ex_v,  r_ex_wr,  r_ex_rd,  i_id_rs1, i_id_use_rs1);
    assign w_a_mem = f_match(r_mem_v, r_mem_wr, r_mem_rd, i_id_rs1, i_id_use_rs1);
    assign w_a_wb  = f_match(r_wb_v,  r_wb_wr,  r_wb_rd,  i_id_rs1, i_id_use_rs1);
    assign w_b_ex  = f_match(r_ex_v,  r_ex_wr,  r_ex_rd,  i_id_rs2, i_id_use_rs2);
    assign w_b_mem = f_match(r_mem_v, r_mem_wr, r_mem_rd, i_id_rs2, i_id_use_rs2);
    assign w_b_wb  = f_match(r_wb_v,  r_wb_wr,  r_wb_rd,  i_id_rs2, i_id_use_rs2);

`ifdef HAZARD_FWD_EN
    assign w_hazard = (w_a_ex | w_b_ex) & r_ex_ld;

    // A load in EX has no result yet, so it is never a forwarding source.
    always_comb begin
        o_fwd_a_sel = 2'b00;
        if (w_a_ex && !r_ex_ld) o_fwd_a_sel = 2'b01;
        else if (w_a_mem)       o_fwd_a_sel = 2'b10;
        else if (w_a_wb)        o_fwd_a_sel = 2'b11;
    end

    always_comb begin
        o_fwd_b_sel = 2'b00;
        if (w_b_ex && !r_ex_ld) o_fwd_b_sel = 2'b01;
        else if (w_b_mem)       o_fwd_b_sel = 2'b10;
        else if (w_b_wb)        o_fwd_b_sel = 2'b11;
    end
`else
    logic w_unused;

    assign w_hazard    = w_a_ex | w_a_mem | w_a_wb | w_b_ex | w_b_mem | w_b_wb;
    assign o_fwd_a_sel = 2'b00;
    assign o_fwd_b_sel = 2'b00;
    assign w_unused    = r_ex_ld;
`endif

    // Reset gating keeps every decode output quiet while rst is held.
    assign w_dec_valid    = i_id_valid & (r_flush_ctr == 2'd0) & ~i_rst;
    assign w_stall        = w_dec_valid & w_hazard;
    assign w_redirect_acc = w_dec_valid & i_id_redirect & ~w_stall;

    assign o_dec_valid = w_dec_valid;
    assign o_stall_if  = w_stall;
    assign o_bubble_ex = w_stall;
    assign o_flush_if  = ((r_flush_ctr != 2'd0) | w_redirect_acc) & ~i_rst;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ex_v      <= 1'b0;
            r_ex_wr     <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_ex_rd     <= 5'd0;
            r_mem_v     <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= 5'd0;
            r_wb_v      <= 1'b0;
            r_wb_wr     <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_flush_ctr <= 2'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_wb_v   <= r_mem_v;
            r_wb_wr  <= r_mem_wr;
            r_wb_rd  <= r_mem_rd;
            r_mem_v  <= r_ex_v;
            r_mem_wr <= r_ex_wr;
            r_mem_rd <= r_ex_rd;

            if (w_stall) begin
                r_ex_v  <= 1'b0;
                r_ex_wr <= 1'b0;
                r_ex_ld <= 1'b0;
                r_ex_rd <= 5'd0;
            end else begin
                r_ex_v  <= w_dec_valid;
                r_ex_wr <= i_id_reg_write;
                r_ex_ld <= i_id_load;
                r_ex_rd <= i_id_rd;
            end

            if (w_redirect_acc)
                r_flush_ctr <= LP_FLUSH_INIT;
            else if (r_flush_ctr != 2'd0)
                r_flush_ctr <= r_flush_ctr - 2'd1;

            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_redirect_acc && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl (FLUSH_CYCLES=2).
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_load, id_redirect;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             dec_valid, stall_if, bubble_ex, flush_if;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0]       obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign obs = {dec_valid, stall_if, bubble_ex, flush_if, fwd_a_sel, fwd_b_sel};

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2), .i_id_rd(id_rd),
        .i_id_reg_write(id_reg_write), .i_id_load(id_load), .i_id_redirect(id_redirect),
        .o_dec_valid(dec_valid), .o_stall_if(stall_if), .o_bubble_ex(bubble_ex),
        .o_flush_if(flush_if), .o_fwd_a_sel(fwd_a_sel), .o_fwd_b_sel(fwd_b_sel),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic redir);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = wr; id_load = ld; id_redirect = redir;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 1, 2, 1, 1, 5, 1, 1, 0);
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        tick();
        @(negedge clk);
        n_tests++;
        if (stall_cnt !== 32'd1) begin
            $display("FAIL rst_pre_cnt: got %0d exp 1", stall_cnt); n_fail++;
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== 8'b0000_0000) begin
            $display("FAIL rst_outputs: got %b exp 00000000", obs); n_fail++;
        end
        n_tests++;
        if ({stall_cnt, flush_cnt} !== 64'd0) begin
            $display("FAIL rst_counters: got %0d/%0d exp 0/0", stall_cnt, flush_cnt); n_fail++;
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1000_0000) begin
            $display("FAIL rst_after_release: got %b exp 10000000", obs); n_fail++;
        end
    endtask

    task automatic test_x0_producer();
        do_reset();
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 1, 1, 9, 1, 0, 0);
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1000_0000) begin
            $display("FAIL x0_no_match: got %b exp 10000000", obs); n_fail++;
        end
    endtask

`ifdef HAZARD_FWD_EN
    task automatic test_load_use();
        do_reset();
        drive(1, 1, 2, 1, 1, 5, 1, 1, 0);
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1110_0000) begin
            $display("FAIL lu_stall: got %b exp 11100000", obs); n_fail++;
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1000_1000) begin
            $display("FAIL lu_fwd_mem: got %b exp 10001000", obs); n_fail++;
        end
        n_tests++;
        if (stall_cnt !== 32'd1) begin
            $display("FAIL lu_stall_cnt: got %0d exp 1", stall_cnt); n_fail++;
        end
    endtask

    task automatic test_fwd_chain();
        do_reset();
        drive(1, 1, 2, 1, 1, 7, 1, 0, 0);
        tick();
        drive(1, 7, 7, 1, 1, 8, 1, 0, 0);
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1000_0101) begin
            $display("FAIL fwd_ex_both: got %b exp 10000101", obs); n_fail++;
        end
        tick();
        drive(1, 7, 8, 1, 1, 9, 1, 0, 0);
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1000_1001) begin
            $display("FAIL fwd_mem_ex: got %b exp 10001001", obs); n_fail++;
        end
        tick();
        drive(1, 7, 8, 1, 1, 10, 1, 0, 0);
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1000_1110) begin
            $display("FAIL fwd_wb_mem: got %b exp 10001110", obs); n_fail++;
        end
    endtask
`else
    task automatic test_raw_stall();
        do_reset();
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1000_0000) begin
            $display("FAIL raw_producer: got %b exp 10000000", obs); n_fail++;
        end
        tick();
        drive(1, 3, 2, 1, 1, 4, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== 8'b1110_0000) begin
                $display("FAIL raw_stall_%0d: got %b exp 11100000", i, obs); n_fail++;
            end
            tick();
        end
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1000_0000) begin
            $display("FAIL raw_release: got %b exp 10000000", obs); n_fail++;
        end
        n_tests++;
        if (stall_cnt !== 32'd3) begin
            $display("FAIL raw_stall_cnt: got %0d exp 3", stall_cnt); n_fail++;
        end
    endtask
`endif

    task automatic test_flush();
        do_reset();
        drive(1, 1, 2, 1, 1, 0, 0, 0, 1);
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1001_0000) begin
            $display("FAIL flush_accept: got %b exp 10010000", obs); n_fail++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            n_tests++;
            if (obs !== 8'b0001_0000) begin
                $display("FAIL flush_cycle_%0d: got %b exp 00010000", i, obs); n_fail++;
            end
        end
        tick();
        drive(1, 1, 2, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (obs !== 8'b1000_0000) begin
            $display("FAIL flush_done: got %b exp 10000000", obs); n_fail++;
        end
        n_tests++;
        if (flush_cnt !== 32'd1) begin
            $display("FAIL flush_cnt: got %0d exp 1", flush_cnt); n_fail++;
        end
    endtask

    task automatic test_redirect_stall();
        int         n_stall;
        logic [1:0] exp_fa;
`ifdef HAZARD_FWD_EN
        n_stall = 1;
        exp_fa  = 2'b10;
`else
        n_stall = 3;
        exp_fa  = 2'b00;
`endif
        do_reset();
        drive(1, 1, 2, 1, 1, 5, 1, 1, 0);
        tick();
        drive(1, 5, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < n_stall; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== 8'b1110_0000) begin
                $display("FAIL rs_stall_%0d: got %b exp 11100000", i, obs); n_fail++;
            end
            tick();
        end
        @(negedge clk);
        n_tests++;
        if (obs !== {6'b1001_00, 2'b00} + {4'b0000, exp_fa, 2'b00}) begin
            $display("FAIL rs_accept: got %b exp %b", obs, {4'b1001, exp_fa, 2'b00}); n_fail++;
        end
        n_tests++;
        if (flush_cnt !== 32'd0) begin
            $display("FAIL rs_cnt_before: got %0d exp 0", flush_cnt); n_fail++;
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        n_tests++;
        if (flush_cnt !== 32'd1) begin
            $display("FAIL rs_flush_cnt: got %0d exp 1", flush_cnt); n_fail++;
        end
        n_tests++;
        if (stall_cnt !== 32'(n_stall)) begin
            $display("FAIL rs_stall_cnt: got %0d exp %0d", stall_cnt, n_stall); n_fail++;
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_x0_producer();
`ifdef HAZARD_FWD_EN
        test_load_use();
        test_fwd_chain();
`else
        test_raw_stall();
`endif
        test_flush();
        test_redirect_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
